// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: captures operands, encodes 16 partials, holds them until the array acknowledges.
// Optional macro BOOTH_ZERO_SKIP_EN adds a zero-operand fast path that bypasses ENCODE.
`timescale 1ns/1ps

module booth_pp_gen #(
    parameter int length = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [length-1:0] rs1,
    input  logic [length-1:0] rs2,
    input  logic              funct3_i,
    input  logic              mult_finish,
    output logic              busy,
    output logic [length:0]   partial1_booth,
    output logic [length:0]   partial2_booth,
    output logic [length:0]   partial3_booth,
    output logic [length:0]   partial4_booth,
    output logic [length:0]   partial5_booth,
    output logic [length:0]   partial6_booth,
    output logic [length:0]   partial7_booth,
    output logic [length:0]   partial8_booth,
    output logic [length:0]   partial9_booth,
    output logic [length:0]   partial10_booth,
    output logic [length:0]   partial11_booth,
    output logic [length:0]   partial12_booth,
    output logic [length:0]   partial13_booth,
    output logic [length:0]   partial14_booth,
    output logic [length:0]   partial15_booth,
    output logic [length:0]   partial16_booth,
    output logic              enable_mult,
    output logic              fuct3,
    output logic              pp_ovf,
    output logic              done
);

    localparam int NPP = 16;
    localparam int PW  = length + 1;
    localparam int BW  = 2 * NPP;

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [length-1:0] a_q, a_d;
    logic [length-1:0] b_q, b_d;
    logic              f3_q, f3_d;
    logic [PW-1:0]     pp_q [NPP];
    logic [PW-1:0]     pp_d [NPP];
    logic              ovf_q, ovf_d;

    logic [PW-1:0]     enc_pp [NPP];
    logic              enc_ovf;
    logic signed [BW-1:0] b_ext;
    logic [BW:0]          b_w;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] a_neg;
    logic signed [PW-1:0] a_two;
    logic signed [PW-1:0] a_ntwo;
    logic                 a_is_min;
    logic [2:0]           trip;

    // Booth digit per 3-bit window; the appended zero below bit 0 supplies B[-1].
    always_comb begin
        enc_pp   = '{default: '0};
        enc_ovf  = 1'b0;
        trip     = 3'b000;
        b_ext    = BW'(signed'(b_q));
        b_w      = {b_ext, 1'b0};
        a_ext    = PW'(signed'(a_q));
        a_neg    = -a_ext;
        a_two    = a_ext <<< 1;
        a_ntwo   = -a_two;
        a_is_min = (a_q == {1'b1, {(length-1){1'b0}}});
        for (int i = 0; i < NPP; i++) begin
            trip = b_w[2*i +: 3];
            case (trip)
                3'b001, 3'b010: enc_pp[i] = a_ext;
                3'b011:         enc_pp[i] = a_two;
                3'b100: begin
                    enc_pp[i] = a_ntwo;
                    if (a_is_min) begin
                        enc_ovf = 1'b1;
                    end
                end
                3'b101, 3'b110: enc_pp[i] = a_neg;
                default:        enc_pp[i] = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        f3_d    = f3_q;
        pp_d    = pp_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d  = rs1;
                    b_d  = rs2;
                    f3_d = funct3_i;
`ifdef BOOTH_ZERO_SKIP_EN
                    if ((rs1 == '0) || (rs2 == '0)) begin
                        pp_d    = '{default: '0};
                        ovf_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        state_d = ENCODE;
                    end
`else
                    state_d = ENCODE;
`endif
                end
            end
            ENCODE: begin
                pp_d    = enc_pp;
                ovf_d   = enc_ovf;
                state_d = HOLD;
            end
            HOLD: begin
                if (mult_finish) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= 1'b0;
            pp_q    <= '{default: '0};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f3_q    <= f3_d;
            pp_q    <= pp_d;
            ovf_q   <= ovf_d;
        end
    end

    // done is combinational so the acknowledge cycle itself closes the transaction.
    assign busy        = (state_q != IDLE);
    assign enable_mult = (state_q == HOLD);
    assign done        = (state_q == HOLD) && mult_finish;
    assign fuct3       = f3_q;
    assign pp_ovf      = ovf_q;

    assign partial1_booth  = pp_q[0];
    assign partial2_booth  = pp_q[1];
    assign partial3_booth  = pp_q[2];
    assign partial4_booth  = pp_q[3];
    assign partial5_booth  = pp_q[4];
    assign partial6_booth  = pp_q[5];
    assign partial7_booth  = pp_q[6];
    assign partial8_booth  = pp_q[7];
    assign partial9_booth  = pp_q[8];
    assign partial10_booth = pp_q[9];
    assign partial11_booth = pp_q[10];
    assign partial12_booth = pp_q[11];
    assign partial13_booth = pp_q[12];
    assign partial14_booth = pp_q[13];
    assign partial15_booth = pp_q[14];
    assign partial16_booth = pp_q[15];

endmodule

// File: tb/tb_booth_pp_gen.sv
// Self-checking bench for booth_pp_gen: arithmetic Booth model, per-cycle compare, directed and random transactions.
`timescale 1ns/1ps

module tb_booth_pp_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        funct3_i;
    logic        mult_finish;
    logic        busy;
    logic        enable_mult;
    logic        fuct3;
    logic        pp_ovf;
    logic        done;
    logic [32:0] dpp [16];

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    int          m_phase;
    logic [31:0] m_a, m_b;
    logic        m_f3;
    logic [32:0] m_pp [16];
    logic        m_ovf;

    always #5 clk = ~clk;

    booth_pp_gen #(.length(32)) dut (
        .clk(clk), .rst(rst), .start(start), .rs1(rs1), .rs2(rs2),
        .funct3_i(funct3_i), .mult_finish(mult_finish), .busy(busy),
        .partial1_booth(dpp[0]),   .partial2_booth(dpp[1]),
        .partial3_booth(dpp[2]),   .partial4_booth(dpp[3]),
        .partial5_booth(dpp[4]),   .partial6_booth(dpp[5]),
        .partial7_booth(dpp[6]),   .partial8_booth(dpp[7]),
        .partial9_booth(dpp[8]),   .partial10_booth(dpp[9]),
        .partial11_booth(dpp[10]), .partial12_booth(dpp[11]),
        .partial13_booth(dpp[12]), .partial14_booth(dpp[13]),
        .partial15_booth(dpp[14]), .partial16_booth(dpp[15]),
        .enable_mult(enable_mult), .fuct3(fuct3), .pp_ovf(pp_ovf),
        .done(done)
    );

    function automatic bit zeroSkip(input logic [31:0] a, input logic [31:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
        return (a == 32'd0) || (b == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Digit_i = -2*B[2i+1] + B[2i] + B[2i-1]; partial is digit*A reduced to 33 bits.
    task automatic modelEncode(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] bw;
        longint sa;
        longint p;
        int d;
        bw = {b, 1'b0};
        sa = longint'($signed(a));
        m_ovf = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d = int'(bw[2*i]) + int'(bw[2*i+1]) - 2 * int'(bw[2*i+2]);
            p = longint'(d) * sa;
            m_pp[i] = p[32:0];
            if (p > 64'sd4294967295 || p < -64'sd4294967296) m_ovf = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_a = '0; m_b = '0; m_f3 = 1'b0; m_ovf = 1'b0;
            for (int i = 0; i < 16; i++) m_pp[i] = '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_a = rs1; m_b = rs2; m_f3 = funct3_i;
                    if (zeroSkip(rs1, rs2)) begin
                        for (int i = 0; i < 16; i++) m_pp[i] = '0;
                        m_ovf = 1'b0;
                        m_phase = 2;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: begin
                    modelEncode(m_a, m_b);
                    m_phase = 2;
                end
                default: if (mult_finish) m_phase = 0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("ctrl{busy,en,done}", {61'd0, busy, enable_mult, done},
                        {61'd0, m_phase != 0, m_phase == 2, (m_phase == 2) && mult_finish});
            checkOutput("fuct3_ovf", {62'd0, fuct3, pp_ovf}, {62'd0, m_f3, m_ovf});
            for (int i = 0; i < 16; i++)
                checkOutput($sformatf("pp%0d", i + 1), {31'd0, dpp[i]}, {31'd0, m_pp[i]});
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic f, output int lat);
        @(posedge clk); #1;
        rs1 = a; rs2 = b; funct3_i = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!enable_mult && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic checkProduct(input string name, input logic [31:0] a, input logic [31:0] b, input bit upper);
        longint s;
        longint e;
        s = 0;
        for (int i = 0; i < 16; i++) s += longint'($signed(dpp[i])) <<< (2 * i);
        e = longint'($signed(a)) * longint'($signed(b));
        if (upper) checkOutput(name, {32'd0, s[63:32]}, {32'd0, e[63:32]});
        else       checkOutput(name, s, e);
    endtask

    task automatic finishTxn(input int hold, input bit start_too);
        logic [32:0] snap [16];
        for (int i = 0; i < 16; i++) snap[i] = dpp[i];
        repeat (hold) begin
            @(posedge clk); #1;
            checkOutput("hold_en", {63'd0, enable_mult}, 64'd1);
            for (int i = 0; i < 16; i++)
                checkOutput("hold_stable", {31'd0, dpp[i]}, {31'd0, snap[i]});
        end
        mult_finish = 1'b1;
        start = start_too;
        rs1 = 32'd9; rs2 = 32'd11;
        #1;
        checkOutput("done_pulse", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        mult_finish = 1'b0;
        start = 1'b0;
        checkOutput("en_after", {63'd0, enable_mult}, 64'd0);
        checkOutput("done_after", {63'd0, done}, 64'd0);
        checkOutput("no_recapture", {63'd0, busy}, 64'd0);
    endtask

    function automatic logic [31:0] pickOperand(input int sel);
        case (sel)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; rs1 = '0; rs2 = '0; funct3_i = 1'b0; mult_finish = 1'b0;
        @(posedge clk); #1;
        checking = 1'b1;
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_pp1", {31'd0, dpp[0]}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(32'd7, 32'd3, 1'b0, lat);
        checkOutput("lat_7x3", lat, 64'd2);
        checkOutput("pp1_7x3", {31'd0, dpp[0]}, 64'h1_FFFF_FFF9);
        checkOutput("pp2_7x3", {31'd0, dpp[1]}, 64'd7);
        checkOutput("pp3_7x3", {31'd0, dpp[2]}, 64'd0);
        checkProduct("prod_7x3", 32'd7, 32'd3, 1'b0);
        finishTxn(5, 1'b0);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
        checkOutput("pp1_m1", {31'd0, dpp[0]}, 64'd1);
        checkOutput("ovf_m1", {63'd0, pp_ovf}, 64'd0);
        checkOutput("fuct3_m1", {63'd0, fuct3}, 64'd1);
        checkProduct("mulh_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        finishTxn(0, 1'b0);

        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
        checkOutput("pp16_min", {31'd0, dpp[15]}, 64'h1_0000_0000);
        checkOutput("ovf_min", {63'd0, pp_ovf}, 64'd1);
        finishTxn(3, 1'b0);

        applyStimulus(32'd5, 32'd9, 1'b1, lat);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_hold_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_hold_en", {63'd0, enable_mult}, 64'd0);
        checkOutput("rst_hold_pp1", {31'd0, dpp[0]}, 64'd0);
        mult_finish = 1'b1;
        #1;
        checkOutput("rst_no_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        mult_finish = 1'b0;

        start = 1'b1; rs1 = 32'd4; rs2 = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_encode_busy", {63'd0, busy}, 64'd0);

        applyStimulus(32'd12345, 32'd0, 1'b0, lat);
        checkOutput("lat_zero_b", lat, zeroSkip(32'd12345, 32'd0) ? 64'd1 : 64'd2);
        checkOutput("pp1_zero_b", {31'd0, dpp[0]}, 64'd0);
        finishTxn(1, 1'b0);
        applyStimulus(32'd0, 32'hDEAD_BEEF, 1'b1, lat);
        checkOutput("lat_zero_a", lat, zeroSkip(32'd0, 32'hDEAD_BEEF) ? 64'd1 : 64'd2);
        finishTxn(0, 1'b1);

        repeat (60) begin
            a = pickOperand($urandom_range(0, 9));
            b = pickOperand($urandom_range(0, 9));
            applyStimulus(a, b, 1'($urandom_range(0, 1)), lat);
            checkOutput("lat_rand", lat, zeroSkip(a, b) ? 64'd1 : 64'd2);
            if (!m_ovf) checkProduct("prod_rand", a, b, 1'b0);
            finishTxn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                mult_finish = 1'b1;
                @(posedge clk); #1;
                mult_finish = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
